// File: rtl/div_mc_if.sv
// div_mc_if: request/response bundle between the EX stage and the
// multi-cycle divider. The master modport is the EX side (it issues and
// cancels requests). The slave modport is the divider itself.
interface div_mc_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_mc.sv
// div_mc: multi-cycle restoring radix-2 divider for the openmips EX stage.
// Handles DIV (signed) and DIVU (unsigned). It returns {remainder, quotient}
// for the HI/LO write. The iteration works on magnitudes. Signs are
// restored when the result is loaded.
// Optional build macro DIV_EARLY_EXIT_EN: when |dividend| < |divisor| the
// result is produced straight from FREE, one edge after accept.
module div_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    div_mc_if.slave  bus
);

    typedef enum logic [1:0] {
        FREE,
        BY_ZERO,
        ON,
        END
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    // Dividend bits shift out of the top of this register while quotient
    // bits shift in at the bottom, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0]      dvd_q, dvd_d;
    logic [WIDTH-1:0]      dsr_q, dsr_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]    result_q, result_d;
    logic                  ready_q, ready_d;

    logic [WIDTH-1:0]      abs1, abs2;
    logic                  early_hit;
    logic [WIDTH:0]        partial;
    logic [WIDTH:0]        diff;
    logic                  quo_bit;
    logic [WIDTH-1:0]      rem_next, dvd_next;
    logic [WIDTH-1:0]      quo_fix, rem_fix;

    // Operand magnitudes. In DIVU mode the operands pass through unchanged.
    always_comb begin
        abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    end

`ifdef DIV_EARLY_EXIT_EN
    assign early_hit = (abs1 < abs2);
`else
    assign early_hit = 1'b0;
`endif

    // One restoring step. The partial remainder is always below the divisor,
    // so bit WIDTH of the (WIDTH+1)-bit difference is a reliable borrow flag.
    // The sign fix-up is applied to the final step's values. A most-negative
    // quotient therefore wraps back to itself.
    always_comb begin
        partial  = {rem_q, dvd_q[WIDTH-1]};
        diff     = partial - {1'b0, dsr_q};
        quo_bit  = ~diff[WIDTH];
        rem_next = quo_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        dvd_next = {dvd_q[WIDTH-2:0], quo_bit};
        quo_fix  = neg_quo_q ? (~dvd_next + 1'b1) : dvd_next;
        rem_fix  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    end

    // State register and datapath. The async active-low reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and next-datapath decode. Annul takes priority in every busy state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    neg_quo_d = bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                    neg_rem_d = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
                    dvd_d     = abs1;
                    dsr_d     = abs2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (bus.opdata2_i == '0) begin
                        state_d = BY_ZERO;
                    end else if (early_hit) begin
                        state_d  = END;
                        result_d = {bus.opdata1_i, {WIDTH{1'b0}}};
                        ready_d  = 1'b1;
                    end else begin
                        state_d = ON;
                    end
                end
            end
            BY_ZERO: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d = rem_next;
                    dvd_d = dvd_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            END: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = (state_q != FREE);

endmodule

// File: tb/tb_div_mc.sv
// tb_div_mc: directed testbench for div_mc at WIDTH=32. It uses
// hand-computed vectors. Edges are counted with the accept edge as edge 1,
// so a full divide shows ready_o after edge WIDTH+1, a divide by zero after
// edge 2, and an early exit (when built with it) after edge 1.
module tb_div_mc;

    localparam int WIDTH = 32;
    localparam int LAT_FULL = WIDTH + 1;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = WIDTH + 1;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_mc_if #(.WIDTH(WIDTH)) bus ();

    div_mc #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sgn, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic start,
                                 input logic annul);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = start;
        bus.annul_i      = annul;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_ready,
                               input logic [2*WIDTH-1:0] exp_result,
                               input logic exp_busy);
        checks++;
        assert (bus.ready_o === exp_ready) else begin
            errors++;
            $error("[TB] FAIL %s ready_o: got %0b expected %0b", tag, bus.ready_o, exp_ready);
        end
        checks++;
        assert (bus.result_o === exp_result) else begin
            errors++;
            $error("[TB] FAIL %s result_o: got %h expected %h", tag, bus.result_o, exp_result);
        end
        checks++;
        assert (bus.busy_o === exp_busy) else begin
            errors++;
            $error("[TB] FAIL %s busy_o: got %0b expected %0b", tag, bus.busy_o, exp_busy);
        end
    endtask

    // Runs one divide with start held. After the accept edge it scrambles the
    // operand inputs, checks ready_o on the exact edge, checks that the result
    // holds while start stays high, and checks that it clears once start drops.
    task automatic runDivide(input string tag, input logic sgn,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int lat, input logic [2*WIDTH-1:0] exp_result);
        applyStimulus(sgn, a, b, 1'b1, 1'b0);
        for (int k = 1; k < lat; k++) begin
            step();
            if (k == 1) applyStimulus(sgn, ~a, ~b, 1'b1, 1'b0);
            checkOutput({tag, " wait"}, 1'b0, '0, 1'b1);
        end
        step();
        checkOutput({tag, " done"}, 1'b1, exp_result, 1'b1);
        step();
        checkOutput({tag, " hold"}, 1'b1, exp_result, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        checkOutput({tag, " clear"}, 1'b0, '0, 1'b0);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

        #12;
        checkOutput("reset", 1'b0, '0, 1'b0);
        #5 rst = 1'b1;
        step();
        checkOutput("idle", 1'b0, '0, 1'b0);

        runDivide("divu_100_7", 1'b0, 32'd100, 32'd7, LAT_FULL, {32'h00000002, 32'h0000000E});
        runDivide("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, LAT_FULL, {32'hFFFFFFFF, 32'hFFFFFFFD});
        runDivide("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, LAT_FULL, {32'h00000001, 32'hFFFFFFFD});
        runDivide("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, LAT_FULL, {32'h00000000, 32'h80000000});
        runDivide("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, LAT_FULL, {32'h00000000, 32'hFFFFFFFF});
        runDivide("divu_55_0", 1'b0, 32'd55, 32'd0, 2, '0);
        runDivide("divu_5_9", 1'b0, 32'd5, 32'd9, LAT_SMALL, {32'h00000005, 32'h00000000});
        runDivide("div_m5_9", 1'b1, 32'hFFFFFFFB, 32'd9, LAT_SMALL, {32'hFFFFFFFB, 32'h00000000});

        // Annul partway through the iterations. Nothing completes afterwards.
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 10; k++) step();
        checkOutput("annul before", 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b1);
        step();
        checkOutput("annul after", 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step();
            checkOutput("annul quiet", 1'b0, '0, 1'b0);
        end
        runDivide("divu_9_3", 1'b0, 32'd9, 32'd3, LAT_FULL, {32'h00000000, 32'h00000003});

        // start and annul together in FREE must not be accepted.
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b1, 1'b1);
        step();
        checkOutput("start_annul 1", 1'b0, '0, 1'b0);
        step();
        checkOutput("start_annul 2", 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        step();

        // Asynchronous reset in the middle of an operation.
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
        step();
        for (int k = 0; k < 5; k++) step();
        checkOutput("pre_reset", 1'b0, '0, 1'b1);
        #1 rst = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        #4 rst = 1'b1;
        step();
        checkOutput("post_reset", 1'b0, '0, 1'b0);
        runDivide("divu_after_rst", 1'b0, 32'd100, 32'd7, LAT_FULL, {32'h00000002, 32'h0000000E});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_mc.md
Name: div_mc

Overview:
- Multi-cycle iterative divider for the EX stage of the openmips pipeline.
- Implements DIV/DIVU as restoring radix-2 division over a parametrised operand width.
- Returns {remainder, quotient} for writing to HI/LO. EX holds the pipeline stalled while busy_o is high.
- The ID/EX flush path cancels an in-flight operation through annul_i.

Parameters:
- WIDTH, 32, operand width in bits (>= 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1_i  in  WIDTH  dividend; sampled at accept.
- opdata2_i  in  WIDTH  divisor; sampled at accept.
- start_i  in  1  request; level, held high by EX until the result is consumed.
- annul_i  in  1  cancel (pipeline flush).
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  out  1  result valid; registered.
- busy_o  out  1  high whenever state != FREE; combinational from the state register.

Behaviour:
- Reset (rst low, asynchronous): state FREE, counter 0, result_o 0, ready_o 0, busy_o 0.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - If start_i=1 and annul_i=0: latch operands and mode.
  - If opdata2_i==0, go to BY_ZERO.
  - Otherwise go to ON with counter 0.
  - Signed mode loads the absolute values of both operands. Each sign is kept.
  - If start_i=1 and annul_i=1 on the same edge: annul wins, stay in FREE.
- BY_ZERO:
  - Next edge goes to END with result_o = 0 and ready_o = 1.
  - Latency is 2 edges from accept.
- ON, one iteration per edge:
  - Shift the partial remainder left and bring in the next dividend bit.
  - Trial-subtract the divisor on a WIDTH+1-bit difference. If non-negative, keep the difference and set the quotient bit to 1.
  - Counter increments. On the edge that completes iteration WIDTH, go to END and load result_o and ready_o = 1.
  - Accept edge to ready_o high is WIDTH+1 edges.
- Sign fix-up is applied when result_o is loaded:
  - Quotient is negated iff signed mode and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0. No flag is raised.
- END:
  - result_o and ready_o hold while start_i=1.
  - When start_i=0 or annul_i=1: next edge goes to FREE with ready_o = 0 and result_o = 0.
- annul_i in ON or BY_ZERO:
  - Next edge goes to FREE with ready_o = 0 and result_o = 0.
  - The partial result is discarded.
- start_i dropping during ON or BY_ZERO does not abort. The operation completes, then END exits on the following edge because start_i=0.
- Operand inputs changing after accept have no effect.
- No new request is accepted until the block has returned to FREE. Back-to-back divides therefore need at least one FREE cycle between them.
- Reset asserted mid-operation returns immediately to the reset values.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In FREE, if the divisor is nonzero and |dividend| < |divisor| (unsigned magnitudes, mode-aware), go straight to END.
  - Quotient = 0. Remainder = dividend unchanged, so its sign is preserved. ready_o is high 1 edge after accept.
  - A dividend of 0 is included in this case.
- Undefined:
  - Every nonzero-divisor operation takes the full WIDTH+1 edges.
  - Results are identical in both builds; only latency differs.

Test Plan (WIDTH=32):
- DIVU 100/7, start held high -> ready_o rises 33 edges after accept; result_o = {0x00000002, 0x0000000E}. Drop start_i -> ready_o=0 and result_o=0 next edge.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- DIVU 55/0 -> BY_ZERO; ready_o high 2 edges after accept with result_o = 0.
- DIVU 1000/3, annul_i pulsed at iteration 10 -> FREE next edge; ready_o never asserts. A following DIVU 9/3 accepted afterwards returns quotient 3, remainder 0. Also: start_i and annul_i high together in FREE -> not accepted.
- rst driven low mid-ON at iteration 5 -> all outputs 0 immediately, without waiting for a clock edge.
- With DIV_EARLY_EXIT_EN: DIVU 5/9 -> ready_o 1 edge after accept, quotient 0, remainder 5. Without the macro: same result after 33 edges.
